// File: rtl/temporal_gemm_if.sv
// Operand/result handshake bundle for temporal_gemm_engine.
// master = operand producer / result consumer, slave = the engine.
interface temporal_gemm_if #(
    parameter int M     = 4,
    parameter int K     = 4,
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int OUT_W = 2*W + $clog2(K)
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   acc_clear;
    logic [M*K*W-1:0]       A;
    logic [K*N*W-1:0]       B;
    logic                   abort;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [M*N*OUT_W-1:0]   out;

    modport master (
        output in_valid, acc_clear, A, B, abort, out_ready,
        input  in_ready, busy, out_valid, out
    );

    modport slave (
        input  in_valid, acc_clear, A, B, abort, out_ready,
        output in_ready, busy, out_valid, out
    );
endinterface

// File: rtl/temporal_gemm_engine.sv
// Temporal-unary signed GEMM: each A element becomes a pulse train of its magnitude,
// and every PE adds or subtracts |B| on each pulse, one pass per K index.
module temporal_gemm_engine #(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int W          = 4,
    parameter bit EARLY_TERM = 1'b0,
    parameter int OUT_W      = 2*W + $clog2(K)
) (
    input  logic           clk,
    input  logic           reset_n,
    temporal_gemm_if.slave bus
);
    localparam int           KW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [W-1:0] FULL_LEN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [W-1:0]     t_q, t_d;
    logic [W-1:0]     a_q   [M][K];
    logic [W-1:0]     b_q   [K][N];
    logic [OUT_W-1:0] acc_q [M][N];

    logic             capture, clear, acc_en, last_tick;
    logic [W-1:0]     a_mag [M];
    logic             a_neg [M];
    logic [W-1:0]     b_mag [N];
    logic             b_neg [N];
    logic             u     [M];
    logic [W-1:0]     len_max, pass_len;

    // Unsigned W-bit magnitude; the most-negative code maps exactly to 2^(W-1).
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        capture = 1'b0;
        clear   = 1'b0;
        acc_en  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            k_d     = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        capture = 1'b1;
                        clear   = bus.acc_clear;
                        state_d = RUN;
                        k_d     = '0;
                        t_d     = '0;
                    end
                end
                RUN: begin
                    acc_en = 1'b1;
                    if (last_tick) begin
                        t_d = '0;
                        if (k_q == KW'(K-1)) state_d = DONE;
                        else                 k_d = k_q + KW'(1);
                    end else begin
                        t_d = t_q + W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);

    // ---------------- operand capture ----------------
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_a_row
            for (genvar gk = 0; gk < K; gk++) begin : g_a_col
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n)     a_q[gi][gk] <= '0;
                    else if (capture) a_q[gi][gk] <= bus.A[(gi*K+gk)*W +: W];
                end
            end
        end
        for (genvar gk = 0; gk < K; gk++) begin : g_b_row
            for (genvar gj = 0; gj < N; gj++) begin : g_b_col
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n)     b_q[gk][gj] <= '0;
                    else if (capture) b_q[gk][gj] <= bus.B[(gk*N+gj)*W +: W];
                end
            end
        end
    endgenerate

    // ---------------- current-pass operands and unary bits ----------------
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_row_sel
            assign a_neg[gi] = a_q[gi][k_q][W-1];
            assign a_mag[gi] = magnitude(a_q[gi][k_q]);
            assign u[gi]     = (t_q < a_mag[gi]);
        end
        for (genvar gj = 0; gj < N; gj++) begin : g_col_sel
            assign b_neg[gj] = b_q[k_q][gj][W-1];
            assign b_mag[gj] = magnitude(b_q[k_q][gj]);
        end
    endgenerate

    // A pass with every A element zero still costs one cycle under early termination.
    always_comb begin
        len_max = '0;
        for (int i = 0; i < M; i++) begin
            if (a_mag[i] > len_max) len_max = a_mag[i];
        end
        if (EARLY_TERM) pass_len = (len_max == '0) ? W'(1) : len_max;
        else            pass_len = FULL_LEN;
    end

    assign last_tick = (t_q == pass_len - W'(1));

    // ---------------- processing elements ----------------
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_pe_row
            for (genvar gj = 0; gj < N; gj++) begin : g_pe_col
                logic [OUT_W-1:0] mag_ext;
                assign mag_ext = OUT_W'(b_mag[gj]);
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        acc_q[gi][gj] <= '0;
                    end else if (clear) begin
                        acc_q[gi][gj] <= '0;
                    end else if (acc_en && u[gi]) begin
                        if (a_neg[gi] ^ b_neg[gj]) acc_q[gi][gj] <= acc_q[gi][gj] - mag_ext;
                        else                       acc_q[gi][gj] <= acc_q[gi][gj] + mag_ext;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        bus.out = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.out[(i*N+j)*OUT_W +: OUT_W] = acc_q[i][j];
            end
        end
    end
endmodule
